hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline hazard and forwarding controller for the 5-stage core. Drives the 2-bit select of the EX-stage
//   operand forwarding muxes (00 pipeline, 01 MA, 10 WB) and the stall/flush controls of the pipeline registers.
//   Handles load-use and taken-branch hazards, and freezes the pipeline while data memory is busy.
//   A watchdog reports a memory wait that runs too long.
// PARAMETERS
//   REG_AW       5    register-index width
//   MEM_TIMEOUT  64   max consecutive MEM_WAIT cycles before mem_timeout sets (>=1)
//   CNT_W        32   width of the statistics counters (HAZARD_STATS_EN only)
// PORTS
//   clk          in   1      clock, rising edge
//   rst_n        in   1      synchronous active-low reset
//   rs1_d,rs2_d  in   REG_AW source regs of the instruction in decode
//   rs1_e,rs2_e  in   REG_AW source regs in execute
//   rd_e         in   REG_AW dest reg in execute
//   is_load_e    in   1      execute instruction is a load
//   pc_src_e     in   1      taken branch/jump resolved in execute
//   rd_m, rd_w   in   REG_AW dest regs in MA / WB
//   reg_write_m  in   1      MA instruction writes rd_m
//   reg_write_w  in   1      WB instruction writes rd_w
//   mem_req_m    in   1      MA stage is accessing data memory
//   mem_ready    in   1      data memory completes the access this cycle
//   forward_a_e  out  2      select for operand A mux
//   forward_b_e  out  2      select for operand B mux
//   stall_f,stall_d,stall_e,stall_m out 1  hold the PC / IF-ID / ID-EX / EX-MA registers
//   flush_d,flush_e,flush_w         out 1  bubble into IF-ID / ID-EX / MA-WB registers
//   mem_timeout  out  1      sticky: a memory wait exceeded MEM_TIMEOUT cycles
// BEHAVIOUR
//   Forwarding (combinational), per operand (rsX_e):
//   - 01 if reg_write_m & rd_m==rsX_e & rsX_e!=0.
//   - else 10 if reg_write_w & rd_w==rsX_e & rsX_e!=0.
//   - else 00. MA beats WB. 11 is never driven.
//   Hazard terms (combinational):
//   - lu  = is_load_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d)
//   - frz = mem_req_m & ~mem_ready
//   Priority, highest first:
//   - frz: stall_f/d/e/m=1, flush_w=1, flush_d=flush_e=0. Branch and load-use are deferred until the freeze ends.
//   - pc_src_e: flush_d=flush_e=1, no stalls. A branch beats a load-use hazard, since the dependent instruction is squashed.
//   - lu: stall_f=stall_d=1, flush_e=1 for the one cycle the condition holds.
//   - otherwise all stall/flush=0.
//   FSM (registered), state encoding RUN=0, MEM_WAIT=1:
//   - RUN->MEM_WAIT when frz. MEM_WAIT->RUN when ~frz.
//   - Outputs depend on frz directly, not on state, so a freeze has zero-cycle latency.
//   Watchdog:
//   - wait_cnt clears in RUN and increments each MEM_WAIT cycle, saturating at MEM_TIMEOUT.
//   - mem_timeout sets on the cycle wait_cnt reaches MEM_TIMEOUT while still frz. It stays set until reset.
//   Reset (rst_n=0 at a clk edge):
//   - state=RUN, wait_cnt=0, mem_timeout=0, statistics counters=0.
//   - Combinational outputs follow their inputs even while rst_n is low.
//   - Reset during MEM_WAIT returns to RUN on the next edge, whatever mem_ready is.
// CONFIGURATION
//   HAZARD_STATS_EN defined:
//   - adds outputs stall_cycles, flush_events, wait_cycles [CNT_W-1:0].
//   - Counts, respectively, cycles with lu & ~frz & ~pc_src_e; cycles with pc_src_e & ~frz; cycles with frz.
//   - Counters wrap at 2^CNT_W and reset to 0.
//   HAZARD_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//   1 rd_m=5,reg_write_m=1,rd_w=5,reg_write_w=1,rs1_e=5 -> forward_a_e=01; drop reg_write_m -> 10; rs1_e=0 -> 00
//   2 is_load_e=1,rd_e=7,rs2_d=7 -> stall_f=stall_d=flush_e=1 for 1 cycle; rd_e=0 -> no stall
//   3 pc_src_e=1 with a load-use hazard in the same cycle -> flush_d=flush_e=1, stall_f=stall_d=0
//   4 mem_req_m=1,mem_ready=0 for 3 cycles, then 1 -> stall_f..m=flush_w=1 for 3 cycles, 0 on the ready cycle
//   5 MEM_TIMEOUT=4, wait held 6 cycles -> mem_timeout rises on the 4th wait cycle and stays 1 after ready; rst_n=0 clears it
//   6 rst_n=0 mid-wait -> state RUN and wait_cnt=0 next edge; with HAZARD_STATS_EN, wait_cycles=0

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
//   master : pipeline side. It drives the register indices, stage flags and
//            memory handshake, and receives the forwarding selects and the
//            stall/flush/timeout controls.
//   slave  : hazard controller side. Same signals, opposite directions.
// REG_AW sets the register-index width.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rs1_d, rs2_d;
  logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
  logic              is_load_e;
  logic              pc_src_e;
  logic [REG_AW-1:0] rd_m, rd_w;
  logic              reg_write_m, reg_write_w;
  logic              mem_req_m, mem_ready;
  logic [1:0]        forward_a_e, forward_b_e;
  logic              stall_f, stall_d, stall_e, stall_m;
  logic              flush_d, flush_e, flush_w;
  logic              mem_timeout;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, is_load_e, pc_src_e,
           rd_m, rd_w, reg_write_m, reg_write_w, mem_req_m, mem_ready,
    input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, mem_timeout
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, is_load_e, pc_src_e,
           rd_m, rd_w, reg_write_m, reg_write_w, mem_req_m, mem_ready,
    output forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, mem_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and forwarding controller for the 5-stage core.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   hz     : hazard_ctrl_if.slave. Inputs are the decode/execute source regs,
//            the EX/MA/WB destinations and write enables, the load and
//            taken-branch flags, and the MA memory request/ready pair.
//            Outputs are the forwarding selects (00 pipe, 01 MA, 10 WB), the
//            stall/flush controls, and the sticky mem_timeout flag.
// Optional feature macro HAZARD_STATS_EN adds the CNT_W-bit counters
//   stall_cycles, flush_events and wait_cycles.
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic rst_n,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] wait_cycles
`endif
);

  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] TMO = WC_W'(MEM_TIMEOUT);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t            state_reg;
  logic [WC_W-1:0]   wait_cnt_reg;
  logic              mem_timeout_reg;
  logic              lu;
  logic              frz;

  // Forwarding: one identical selector per EX operand. MA is checked first so
  // the youngest producer wins; x0 is never forwarded.
  logic [REG_AW-1:0] rs_e [2];
  logic [1:0]        fwd_sel [2];

  assign rs_e[0] = hz.rs1_e;
  assign rs_e[1] = hz.rs2_e;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_sel[gi] = 2'b00;
        if (rs_e[gi] != ZERO_REG) begin
          if (hz.reg_write_m && (hz.rd_m == rs_e[gi]))
            fwd_sel[gi] = 2'b01;
          else if (hz.reg_write_w && (hz.rd_w == rs_e[gi]))
            fwd_sel[gi] = 2'b10;
        end
      end
    end
  endgenerate

  assign hz.forward_a_e = fwd_sel[0];
  assign hz.forward_b_e = fwd_sel[1];

  assign lu  = hz.is_load_e && (hz.rd_e != ZERO_REG) &&
               ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
  assign frz = hz.mem_req_m && !hz.mem_ready;

  // Stall/flush decode works straight off frz (not the state register) so a
  // memory freeze takes effect in the same cycle it appears.
  always_comb begin
    hz.stall_f = 1'b0;
    hz.stall_d = 1'b0;
    hz.stall_e = 1'b0;
    hz.stall_m = 1'b0;
    hz.flush_d = 1'b0;
    hz.flush_e = 1'b0;
    hz.flush_w = 1'b0;
    if (frz) begin
      hz.stall_f = 1'b1;
      hz.stall_d = 1'b1;
      hz.stall_e = 1'b1;
      hz.stall_m = 1'b1;
      hz.flush_w = 1'b1;
    end else if (hz.pc_src_e) begin
      // The branch squashes the dependent instruction, so it beats load-use.
      hz.flush_d = 1'b1;
      hz.flush_e = 1'b1;
    end else if (lu) begin
      hz.stall_f = 1'b1;
      hz.stall_d = 1'b1;
      hz.flush_e = 1'b1;
    end
  end

  // Wait-tracking FSM and watchdog. wait_cnt counts MEM_WAIT cycles already
  // completed, so the current MEM_WAIT cycle is number wait_cnt+1; the flag
  // sets once that number reaches MEM_TIMEOUT with the freeze still present.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          wait_cnt_reg <= '0;
          if (frz) state_reg <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (wait_cnt_reg != TMO) wait_cnt_reg <= wait_cnt_reg + WC_W'(1);
          if (frz && (wait_cnt_reg >= (TMO - WC_W'(1)))) mem_timeout_reg <= 1'b1;
          if (!frz) state_reg <= RUN;
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign hz.mem_timeout = mem_timeout_reg;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cycles_reg, flush_events_reg, wait_cycles_reg;

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_reg <= '0;
      flush_events_reg <= '0;
      wait_cycles_reg  <= '0;
    end else begin
      if (lu && !frz && !hz.pc_src_e) stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
      if (hz.pc_src_e && !frz)        flush_events_reg <= flush_events_reg + CNT_W'(1);
      if (frz)                        wait_cycles_reg  <= wait_cycles_reg + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_events = flush_events_reg;
  assign wait_cycles  = wait_cycles_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios followed by a randomized run, every cycle
// compared against a behavioural model of the forwarding/hazard rules.
module tb_hazard_ctrl;
  localparam int AW  = 5;
  localparam int MT  = 4;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(AW)) bus ();

`ifdef HAZARD_STATS_EN
  logic [CW-1:0] stall_cycles, flush_events, wait_cycles;
`endif

  hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
    .wait_cycles  (wait_cycles)
`endif
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int step_no = 0;

  // Reference model state: length of the current unbroken freeze run, the
  // sticky timeout, and the statistics totals.
  int run_len = 0;
  bit m_timeout = 1'b0;
  int m_stall = 0, m_flush = 0, m_wait = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s step %0d: got %0h expected %0h", tag, step_no, obs, exp);
  endtask

  function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
    if (rs == 0) return 2'b00;
    if (bus.reg_write_m && bus.rd_m == rs) return 2'b01;
    if (bus.reg_write_w && bus.rd_w == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit m_frz();
    return bus.mem_req_m && !bus.mem_ready;
  endfunction

  function automatic bit m_lu();
    return bus.is_load_e && bus.rd_e != 0 &&
           (bus.rd_e == bus.rs1_d || bus.rd_e == bus.rs2_d);
  endfunction

  // Compare all outputs for the inputs currently applied, clock once, then
  // advance the model with the same inputs.
  task automatic step();
    logic [3:0] exp_stall;
    logic [2:0] exp_flush;
    #1;
    step_no++;
    if (m_frz())              begin exp_stall = 4'b1111; exp_flush = 3'b001; end
    else if (bus.pc_src_e)    begin exp_stall = 4'b0000; exp_flush = 3'b110; end
    else if (m_lu())          begin exp_stall = 4'b1100; exp_flush = 3'b010; end
    else                      begin exp_stall = 4'b0000; exp_flush = 3'b000; end
    check("forward_a_e", 32'(bus.forward_a_e), 32'(exp_fwd(bus.rs1_e)));
    check("forward_b_e", 32'(bus.forward_b_e), 32'(exp_fwd(bus.rs2_e)));
    check("stall_fdem", 32'({bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m}), 32'(exp_stall));
    check("flush_dew", 32'({bus.flush_d, bus.flush_e, bus.flush_w}), 32'(exp_flush));
    check("mem_timeout", 32'(bus.mem_timeout), 32'(m_timeout));
`ifdef HAZARD_STATS_EN
    check("stall_cycles", 32'(stall_cycles), 32'(m_stall % (1 << CW)));
    check("flush_events", 32'(flush_events), 32'(m_flush % (1 << CW)));
    check("wait_cycles",  32'(wait_cycles),  32'(m_wait % (1 << CW)));
`endif
    $display("step %0d rst_n=%0b frz=%0b pc=%0b lu=%0b fa=%0b fb=%0b to=%0b",
             step_no, rst_n, m_frz(), bus.pc_src_e, m_lu(),
             bus.forward_a_e, bus.forward_b_e, bus.mem_timeout);
    @(posedge clk);
    if (!rst_n) begin
      run_len = 0; m_timeout = 1'b0; m_stall = 0; m_flush = 0; m_wait = 0;
    end else begin
      if (m_frz()) begin
        run_len++;
        // The first frozen cycle is spent leaving RUN; the watchdog counts
        // the MEM_WAIT cycles that follow it.
        if (run_len - 1 >= MT) m_timeout = 1'b1;
        m_wait++;
      end else begin
        run_len = 0;
      end
      if (m_lu() && !m_frz() && !bus.pc_src_e) m_stall++;
      if (bus.pc_src_e && !m_frz()) m_flush++;
    end
    #1;
  endtask

  task automatic idle();
    bus.rs1_d = '0; bus.rs2_d = '0; bus.rs1_e = '0; bus.rs2_e = '0; bus.rd_e = '0;
    bus.is_load_e = 1'b0; bus.pc_src_e = 1'b0;
    bus.rd_m = '0; bus.rd_w = '0; bus.reg_write_m = 1'b0; bus.reg_write_w = 1'b0;
    bus.mem_req_m = 1'b0; bus.mem_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;
    step();

    // 1: forwarding priority MA > WB, x0 never forwarded
    bus.rd_m = 5; bus.reg_write_m = 1; bus.rd_w = 5; bus.reg_write_w = 1; bus.rs1_e = 5;
    step();
    check("t1_fwd_ma", 32'(bus.forward_a_e), 32'h1);
    bus.reg_write_m = 0; #1;
    check("t1_fwd_wb", 32'(bus.forward_a_e), 32'h2);
    step();
    bus.rs1_e = 0; #1;
    check("t1_fwd_x0", 32'(bus.forward_a_e), 32'h0);
    step();
    idle();

    // 2: load-use stall, then rd_e=0 gives none
    bus.is_load_e = 1; bus.rd_e = 7; bus.rs2_d = 7; #1;
    check("t2_lu", 32'({bus.stall_f, bus.stall_d, bus.flush_e}), 32'h7);
    step();
    bus.rd_e = 0; bus.rs2_d = 0; #1;
    check("t2_lu_x0", 32'({bus.stall_f, bus.stall_d, bus.flush_e}), 32'h0);
    step();

    // 3: branch beats load-use
    bus.rd_e = 7; bus.rs1_d = 7; bus.pc_src_e = 1; #1;
    check("t3_branch", 32'({bus.flush_d, bus.flush_e, bus.stall_f, bus.stall_d}), 32'hC);
    step();
    idle();

    // 4: three frozen cycles then ready
    bus.mem_req_m = 1; bus.mem_ready = 0;
    for (int i = 0; i < 3; i++) step();
    bus.mem_ready = 1; #1;
    check("t4_ready", 32'({bus.stall_f, bus.stall_m, bus.flush_w}), 32'h0);
    step();
    idle();

    // 5: watchdog after a six-cycle wait, sticky until reset
    bus.mem_req_m = 1; bus.mem_ready = 0;
    for (int i = 0; i < 6; i++) step();
    bus.mem_ready = 1;
    step();
    idle();
    check("t5_sticky", 32'(bus.mem_timeout), 32'h1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_cleared", 32'(bus.mem_timeout), 32'h0);
    step();

    // 6: reset in the middle of a wait restarts the watchdog count
    bus.mem_req_m = 1; bus.mem_ready = 0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("t6_no_timeout", 32'(bus.mem_timeout), 32'h0);
    bus.mem_ready = 1;
    step();
    idle();

    // Randomized traffic with small register indices so matches are frequent.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      bus.rs1_d = AW'($urandom_range(0, 3)); bus.rs2_d = AW'($urandom_range(0, 3));
      bus.rs1_e = AW'($urandom_range(0, 3)); bus.rs2_e = AW'($urandom_range(0, 3));
      bus.rd_e  = AW'($urandom_range(0, 3));
      bus.rd_m  = AW'($urandom_range(0, 3)); bus.rd_w = AW'($urandom_range(0, 3));
      bus.is_load_e   = 1'($urandom_range(0, 1));
      bus.pc_src_e    = ($urandom_range(0, 4) == 0);
      bus.reg_write_m = 1'($urandom_range(0, 1));
      bus.reg_write_w = 1'($urandom_range(0, 1));
      bus.mem_req_m   = ($urandom_range(0, 2) != 0);
      bus.mem_ready   = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
